// File: rtl/temp_mon_pkg.sv
// Shared types and widths for the temperature-monitor scheduler.
package temp_mon_pkg;

  localparam int BASE_W = 5;
  localparam int COEF_W = 4;
  localparam int VAL_W  = 4;
  localparam int CNT_W  = 4;
  localparam int GAP_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_SAMPLE = 3'd2,
    ST_UPDATE = 3'd3,
    ST_GAP    = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    CLS_NORMAL = 2'd0,
    CLS_LOW    = 2'd1,
    CLS_HIGH   = 2'd2
  } cls_e;

  // High outranks low when the detector raises both flags.
  function automatic cls_e classify(input logic low, input logic high);
    cls_e c;
    if (high) begin
      c = CLS_HIGH;
    end else if (low) begin
      c = CLS_LOW;
    end else begin
      c = CLS_NORMAL;
    end
    return c;
  endfunction

endpackage

// File: rtl/temp_mon_debounce.sv
// Per-channel debounce: tracks the last class and its run length, and
// drives the low/high alarm once the run reaches DEBOUNCE samples.
module temp_mon_debounce
  import temp_mon_pkg::*;
#(
  parameter int DEBOUNCE = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic upd,
  input  cls_e cls,
  output logic low_alarm,
  output logic high_alarm
);

  localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEBOUNCE);

  cls_e             cls_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;

  // Run length after this sample: saturate on a repeat, restart at 1 on a change.
  always_comb begin
    cnt_next_s = 4'd1;
    if (cls == cls_r) begin
      if (cnt_r >= DEB_MAX) begin
        cnt_next_s = DEB_MAX;
      end else begin
        cnt_next_s = cnt_r + 4'd1;
      end
    end else begin
      cnt_next_s = 4'd1;
    end
  end

  // Class/count history and alarm state; a clear wipes history but keeps alarms.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cls_r      <= CLS_NORMAL;
      cnt_r      <= 4'd0;
      low_alarm  <= 1'b0;
      high_alarm <= 1'b0;
    end else if (clr) begin
      cls_r <= CLS_NORMAL;
      cnt_r <= 4'd0;
    end else if (upd) begin
      cls_r <= cls;
      cnt_r <= cnt_next_s;
      if (cnt_next_s == DEB_MAX) begin
        low_alarm  <= (cls == CLS_LOW);
        high_alarm <= (cls == CLS_HIGH);
      end
    end
  end

endmodule

// File: rtl/temp_monitor_scheduler.sv
// Round-robin scheduler sharing one external abnormality detector across
// NUM_SENSORS channels, with per-channel debounced low/high alarms.
module temp_monitor_scheduler
  import temp_mon_pkg::*;
#(
  parameter int NUM_SENSORS = 4,
  parameter int DEBOUNCE    = 3,
  parameter int SCAN_GAP    = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               enable,
  input  logic                               cfgWe,
  input  logic [BASE_W-1:0]                  cfgBaseTemp,
  input  logic [COEF_W-1:0]                  cfgTempCoef,
  input  logic [VAL_W*NUM_SENSORS-1:0]       sensorValues,
  input  logic [NUM_SENSORS-1:0]             sensorValid,
  output logic [BASE_W-1:0]                  detBaseTemp,
  output logic [COEF_W-1:0]                  detTempCoef,
  output logic [VAL_W-1:0]                   detSensorValue,
  input  logic                               detLow,
  input  logic                               detHigh,
  output logic [$clog2(NUM_SENSORS)-1:0]     curChannel,
  output logic [NUM_SENSORS-1:0]             lowAlarm,
  output logic [NUM_SENSORS-1:0]             highAlarm,
  output logic                               alarmIrq,
  output logic                               scanDone
);

  localparam int               CH_W     = $clog2(NUM_SENSORS);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_SENSORS - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(SCAN_GAP - 1);

  state_e             st_r;
  logic [CH_W-1:0]    ch_r;
  logic [GAP_W-1:0]   gap_r;
  logic               valid_r;
  cls_e               samp_cls_r;
  logic               stop_s;
  logic               restart_s;
  logic               clr_s;
  logic               upd_s;
  logic [NUM_SENSORS-1:0] low_s;
  logic [NUM_SENSORS-1:0] high_s;
  logic [NUM_SENSORS-1:0] low_prev_r;
  logic [NUM_SENSORS-1:0] high_prev_r;

  assign curChannel = ch_r;
  assign lowAlarm   = low_s;
  assign highAlarm  = high_s;

  // Abort conditions: enable drop wins over a config-write restart.
  always_comb begin
    stop_s    = (st_r != ST_IDLE) && !enable;
    restart_s = (st_r != ST_IDLE) && enable && cfgWe;
    clr_s     = (st_r != ST_IDLE) && cfgWe;
    upd_s     = (st_r == ST_UPDATE) && valid_r && !stop_s && !restart_s;
  end

  // Scan FSM: settle/sample/update per channel, then an optional idle gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_r           <= ST_IDLE;
      ch_r           <= {CH_W{1'b0}};
      gap_r          <= 8'd0;
      valid_r        <= 1'b0;
      samp_cls_r     <= CLS_NORMAL;
      detSensorValue <= 4'd0;
      scanDone       <= 1'b0;
    end else begin
      scanDone <= 1'b0;
      if (stop_s) begin
        st_r  <= ST_IDLE;
        ch_r  <= {CH_W{1'b0}};
        gap_r <= 8'd0;
      end else if (restart_s) begin
        st_r  <= ST_SETTLE;
        ch_r  <= {CH_W{1'b0}};
        gap_r <= 8'd0;
      end else begin
        case (st_r)
          ST_IDLE: begin
            if (enable) begin
              st_r <= ST_SETTLE;
              ch_r <= {CH_W{1'b0}};
            end
          end
          ST_SETTLE: begin
            detSensorValue <= sensorValues[int'(ch_r)*VAL_W +: VAL_W];
            valid_r        <= sensorValid[ch_r];
            st_r           <= ST_SAMPLE;
          end
          ST_SAMPLE: begin
            samp_cls_r <= classify(detLow, detHigh);
            st_r       <= ST_UPDATE;
          end
          ST_UPDATE: begin
            if (ch_r == CH_LAST) begin
              scanDone <= 1'b1;
              ch_r     <= {CH_W{1'b0}};
              gap_r    <= 8'd0;
              st_r     <= (SCAN_GAP == 0) ? ST_SETTLE : ST_GAP;
            end else begin
              ch_r <= ch_r + CH_W'(1);
              st_r <= ST_SETTLE;
            end
          end
          ST_GAP: begin
            if (gap_r == GAP_LAST) begin
              gap_r <= 8'd0;
              st_r  <= ST_SETTLE;
            end else begin
              gap_r <= gap_r + 8'd1;
            end
          end
          default: begin
            st_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // Factory config registers load on any write strobe, whatever the FSM state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      detBaseTemp <= 5'd0;
      detTempCoef <= 4'd0;
    end else if (cfgWe) begin
      detBaseTemp <= cfgBaseTemp;
      detTempCoef <= cfgTempCoef;
    end
  end

  // IRQ one cycle after any alarm bit differs from its previous value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      low_prev_r  <= {NUM_SENSORS{1'b0}};
      high_prev_r <= {NUM_SENSORS{1'b0}};
      alarmIrq    <= 1'b0;
    end else begin
      low_prev_r  <= low_s;
      high_prev_r <= high_s;
      alarmIrq    <= (|(low_s ^ low_prev_r)) | (|(high_s ^ high_prev_r));
    end
  end

  for (genvar i = 0; i < NUM_SENSORS; i++) begin : g_ch
    temp_mon_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (clr_s),
      .upd        (upd_s && (ch_r == CH_W'(i))),
      .cls        (samp_cls_r),
      .low_alarm  (low_s[i]),
      .high_alarm (high_s[i])
    );
  end

endmodule
